cnn_pixel_streamer: RTL and testbench
=====================================

Name: cnn_pixel_streamer

Overview:
- Frame source for the CNN datapath.
- Fetches a WIDTH x HEIGHT 8-bit image from system memory over a req/gnt/rvalid read port, with 32-bit words holding 4 pixels.
- Streams the pixels in raster order as a valid/ready pixel stream with start-of-line and end-of-frame markers.
- Its output drives the pixel_in/valid_in side of the 3x3 line buffer; ready_in is tied high there.

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- WIDTH, 28, pixels per row.
- HEIGHT, 28, rows per frame.
- ADDR_WIDTH, 32, memory address width (byte address).
- BUS_WIDTH, 32, memory data width; must be a multiple of DATA_WIDTH. PPW = BUS_WIDTH/DATA_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- base_addr  in  ADDR_WIDTH  byte address of pixel 0, sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last pixel handshake.
- mem_req  out  1  read request.
- mem_addr  out  ADDR_WIDTH  word-aligned read address.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  BUS_WIDTH  read data.
- pixel_out  out  DATA_WIDTH  current pixel.
- valid_out  out  1  pixel_out valid.
- ready_in  in  1  consumer accepts the pixel.
- sol  out  1  qualifies valid_out; current pixel is column 0.
- eof  out  1  qualifies valid_out; current pixel is the last of the frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; busy, done, mem_req, valid_out, sol, eof = 0; mem_addr, pixel_out = 0; all counters and the word buffer = 0. Reset asserted mid-frame aborts immediately. Outstanding memory responses arriving after reset are ignored.
- FSM states: IDLE, REQ, WAIT, EMIT, DONE.
- IDLE:
  - start=1 latches base_addr with the low log2(BUS_WIDTH/8) bits forced to 0.
  - Clears word_idx, lane, col, row, and pix_cnt; goes to REQ.
  - start in any other state is ignored.
- REQ:
  - mem_req=1, mem_addr = base + word_idx*(BUS_WIDTH/8).
  - mem_req and mem_addr are held stable until mem_gnt; on mem_gnt go to WAIT.
- WAIT:
  - mem_req=0. On mem_rvalid, latch mem_rdata into the word buffer, set lane=0, go to EMIT.
  - mem_rvalid outside WAIT is ignored.
  - rvalid is never expected in the same cycle as gnt; earliest is the next cycle.
- EMIT:
  - valid_out=1. pixel_out = word_buf[lane*DATA_WIDTH +: DATA_WIDTH]; lane 0 is the least significant bits.
  - sol = (col==0). eof = (pix_cnt == WIDTH*HEIGHT-1).
  - pixel_out, sol, and eof are stable while valid_out && !ready_in.
  - On valid_out && ready_in:
    - pix_cnt++.
    - col wraps from WIDTH-1 to 0 and row++ at the wrap.
    - If eof, go to DONE; the remaining lanes of the last word are discarded.
    - Else if lane==PPW-1, word_idx++ and go to REQ.
    - Else lane++, staying in EMIT.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Counter widths:
  - pix_cnt is $clog2(WIDTH*HEIGHT+1) bits.
  - word_idx is $clog2(ceil(WIDTH*HEIGHT/PPW)) bits.
  - No pixel count overflow is possible.
- Address arithmetic: computed in ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH, with no error.
- Latency:
  - start at cycle 0 gives mem_req at cycle 1.
  - With gnt at cycle 1 and rvalid at cycle 2, the first valid_out is at cycle 3.
- Throughput: at most PPW pixels per (PPW + 2 + memory latency) cycles. No prefetch.

Decomposition:
- cnn_pkg holds:
  - the state enum cnn_stream_state_e;
  - localparams PPW and BYTES_PER_WORD;
  - the helper function for the pixel-count width.
- No sub-module; a single FSM with counters.

Test Plan:
- Default params, memory holding byte value = address[7:0], zero-wait gnt, rvalid next cycle, ready_in=1:
  - exactly 784 valid_out handshakes;
  - pixel n = (base+n)[7:0];
  - sol at n = 0, 28, 56, ...;
  - eof only at n=783;
  - 196 mem_req grants, last mem_addr = base+780;
  - done pulses once.
- Word 0x44332211 at base, ready_in=1: pixel_out sequence 0x11, 0x22, 0x33, 0x44, then the next mem_req.
- Random gnt stalls (0-5 cycles) and ready_in low for 3 cycles mid-word:
  - mem_addr and mem_req stable while !gnt;
  - pixel_out stable while !ready_in;
  - no pixel lost or duplicated.
- WIDTH=5, HEIGHT=3 (15 px, 4 words): last word lane 3 is never emitted; eof at the 15th pixel; done one cycle later.
- start pulsed while busy, and base_addr=0x1003: the second start is ignored; the first fetch address is 0x1000.
- rst_n asserted in WAIT then released, and a stray rvalid arrives: all outputs are 0; the stray rvalid is ignored; a new start restarts from word 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN pixel streamer.
package cnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } cnn_stream_state_e;

    // Default geometry: 8-bit pixels packed four to a 32-bit word.
    localparam int unsigned PPW            = 4;
    localparam int unsigned BYTES_PER_WORD = 4;

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnn_pixel_streamer.sv
// Fetches a WIDTH x HEIGHT frame word by word from memory and streams it
// out pixel by pixel in raster order with start-of-line / end-of-frame marks.
module cnn_pixel_streamer
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WIDTH      = 28,
    parameter int unsigned HEIGHT     = 28,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BUS_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [BUS_WIDTH-1:0]  mem_rdata,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  sol,
    output logic                  eof
);

    localparam int unsigned LANES      = BUS_WIDTH / DATA_WIDTH;
    localparam int unsigned WORD_BYTES = BUS_WIDTH / 8;
    localparam int unsigned NUM_PIX    = WIDTH * HEIGHT;
    localparam int unsigned NUM_WORDS  = (NUM_PIX + LANES - 1) / LANES;
    localparam int unsigned PCW        = cnt_width(NUM_PIX + 1);
    localparam int unsigned WIW        = cnt_width(NUM_WORDS);
    localparam int unsigned LW         = cnt_width(LANES);
    localparam int unsigned CW         = cnt_width(WIDTH);
    localparam int unsigned RW         = cnt_width(HEIGHT + 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WORD_BYTES - 1);

    cnn_stream_state_e state, state_nxt;

    logic [ADDR_WIDTH-1:0] base;
    logic [WIW-1:0]        word_idx;
    logic [LW-1:0]         lane;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [PCW-1:0]        pix_cnt;
    logic [BUS_WIDTH-1:0]  word_buf;
    logic                  last_pix;
    logic                  last_lane;

    assign last_pix  = (pix_cnt == PCW'(NUM_PIX - 1));
    assign last_lane = (lane == LW'(LANES - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs, all decoded from the current state.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        valid_out = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_REQ;
            ST_REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_gnt) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (mem_rvalid) state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                busy      = 1'b1;
                valid_out = 1'b1;
                if (ready_in) begin
                    if (last_pix)       state_nxt = ST_DONE;
                    else if (last_lane) state_nxt = ST_REQ;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address, current pixel and frame markers derived from the counters.
    always_comb begin
        mem_addr  = base + ADDR_WIDTH'(word_idx) * ADDR_WIDTH'(WORD_BYTES);
        pixel_out = '0;
        if (valid_out) pixel_out = word_buf[lane * DATA_WIDTH +: DATA_WIDTH];
        sol = valid_out && (col == '0);
        eof = valid_out && last_pix;
    end

    // Frame counters and the word buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base     <= '0;
            word_idx <= '0;
            lane     <= '0;
            col      <= '0;
            row      <= '0;
            pix_cnt  <= '0;
            word_buf <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    base     <= base_addr & ALIGN_MASK;
                    word_idx <= '0;
                    lane     <= '0;
                    col      <= '0;
                    row      <= '0;
                    pix_cnt  <= '0;
                end
                ST_WAIT: if (mem_rvalid) begin
                    word_buf <= mem_rdata;
                    lane     <= '0;
                end
                ST_EMIT: if (ready_in) begin
                    pix_cnt <= pix_cnt + PCW'(1);
                    if (col == CW'(WIDTH - 1)) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                    // Past the final pixel the rest of the word is dropped.
                    if (!last_pix) begin
                        if (last_lane) word_idx <= word_idx + WIW'(1);
                        else           lane     <= lane + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// Randomized bench for cnn_pixel_streamer: a 28x28 instance and a 5x3 instance
// driven by a behavioural memory, checked against a frame-level reference.
module tb_cnn_pixel_streamer;

    typedef struct { int inst; int cyc; logic [9:0] v; } hs_t;   // {eof, sol, pixel}
    typedef struct { int inst; int cyc; logic [31:0] a; } gr_t;
    typedef struct { int inst; int cyc; } dn_t;

    logic        clk;
    logic        rst_n[2], start[2], busy[2], done[2], mem_req[2], gnt[2];
    logic        rvalid[2], valid[2], ready[2], sol[2], eof[2];
    logic [31:0] base[2], addr[2], rdata[2];
    logic [7:0]  pix[2];

    // Environment controls, written by the stimulus process only.
    bit          stall_mode[2], ready_mode[2], hold_rv[2], stray[2];
    bit          ovr_en;
    logic [31:0] ovr_addr, ovr_word;

    // Environment state, written by the negedge process only.
    int          cyc;
    bit          pend[2], req_wait[2], px_wait[2];
    logic [31:0] pend_addr[2], prev_addr[2];
    logic [9:0]  prev_px[2];
    int unsigned stall_left[2], low_left[2];
    int          viol[2];
    hs_t         hs_q[$];
    gr_t         gr_q[$];
    dn_t         dn_q[$];

    // Results gathered by run_frame.
    hs_t         col_hs[$];
    gr_t         col_gr[$];

    int          checks, errors;

    cnn_pixel_streamer u_big (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .base_addr(base[0]),
        .busy(busy[0]), .done(done[0]), .mem_req(mem_req[0]), .mem_addr(addr[0]),
        .mem_gnt(gnt[0]), .mem_rvalid(rvalid[0]), .mem_rdata(rdata[0]),
        .pixel_out(pix[0]), .valid_out(valid[0]), .ready_in(ready[0]),
        .sol(sol[0]), .eof(eof[0])
    );

    cnn_pixel_streamer #(.WIDTH(5), .HEIGHT(3)) u_small (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .base_addr(base[1]),
        .busy(busy[1]), .done(done[1]), .mem_req(mem_req[1]), .mem_addr(addr[1]),
        .mem_gnt(gnt[1]), .mem_rvalid(rvalid[1]), .mem_rdata(rdata[1]),
        .pixel_out(pix[1]), .valid_out(valid[1]), .ready_in(ready[1]),
        .sol(sol[1]), .eof(eof[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content: each byte holds its own address[7:0], unless overridden.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] a1, a2, a3;
        if (ovr_en && a == ovr_addr) return ovr_word;
        a1 = a + 1; a2 = a + 2; a3 = a + 3;
        return {a3[7:0], a2[7:0], a1[7:0], a[7:0]};
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word({a[31:2], 2'b00});
        return w[8 * a[1:0] +: 8];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int count_dn(input int inst, input int from);
        int c = 0;
        for (int k = from; k < dn_q.size(); k++) if (dn_q[k].inst == inst) c++;
        return c;
    endfunction

    function automatic int count_gr(input int inst, input int from);
        int c = 0;
        for (int k = from; k < gr_q.size(); k++) if (gr_q[k].inst == inst) c++;
        return c;
    endfunction

    // Memory responder, ready generator and protocol monitor, away from posedge.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            gnt[i]    = 1'b0;
            rvalid[i] = 1'b0;
            if (!rst_n[i]) begin
                pend[i] = 0; req_wait[i] = 0; px_wait[i] = 0;
                ready[i] = 1'b1; low_left[i] = 0; rdata[i] = '0;
            end else begin
                if (stray[i]) begin
                    rvalid[i] = 1'b1;
                    rdata[i]  = 32'hDEADBEEF;
                end else if (pend[i]) begin
                    if (!hold_rv[i]) begin
                        rvalid[i] = 1'b1;
                        rdata[i]  = mem_word(pend_addr[i]);
                        pend[i]   = 0;
                    end
                end else if (mem_req[i]) begin
                    if (req_wait[i] && addr[i] !== prev_addr[i]) viol[i]++;
                    if (stall_left[i] == 0 || !stall_mode[i]) begin
                        gnt[i]       = 1'b1;
                        pend[i]      = 1;
                        pend_addr[i] = addr[i];
                        gr_q.push_back('{i, cyc, addr[i]});
                        stall_left[i] = stall_mode[i] ? $urandom_range(0, 5) : 0;
                        req_wait[i]   = 0;
                    end else begin
                        stall_left[i]--;
                        req_wait[i]  = 1;
                        prev_addr[i] = addr[i];
                    end
                end else if (req_wait[i]) begin
                    viol[i]++;
                    req_wait[i] = 0;
                end

                if (ready_mode[i]) begin
                    if (low_left[i] > 0) begin
                        ready[i] = 1'b0;
                        low_left[i]--;
                    end else if (valid[i] && $urandom_range(0, 5) == 0) begin
                        ready[i]    = 1'b0;
                        low_left[i] = 2;
                    end else begin
                        ready[i] = 1'b1;
                    end
                end else begin
                    ready[i] = 1'b1;
                end

                if (px_wait[i] && (!valid[i] || {eof[i], sol[i], pix[i]} !== prev_px[i]))
                    viol[i]++;
                if (valid[i] && ready[i]) hs_q.push_back('{i, cyc, {eof[i], sol[i], pix[i]}});
                px_wait[i] = valid[i] && !ready[i];
                prev_px[i] = {eof[i], sol[i], pix[i]};
                if (done[i]) dn_q.push_back('{i, cyc});
            end
        end
    end

    // Run one frame and compare everything observed with the frame-level reference.
    task automatic run_frame(input int inst, input logic [31:0] b, input int w, input int h,
                             input bit dbl, input string tag);
        int hs0, gr0, dn0, v0, c0, waited, n_pix, n_words;
        logic [31:0] a0;
        hs0 = hs_q.size(); gr0 = gr_q.size(); dn0 = dn_q.size(); v0 = viol[inst];
        n_pix   = w * h;
        n_words = (n_pix + 3) / 4;
        a0      = b & ~32'h3;

        @(posedge clk); #2;
        base[inst] = b; start[inst] = 1'b1; c0 = cyc;
        @(posedge clk); #2;
        start[inst] = 1'b0;
        if (dbl) begin
            repeat (4) @(posedge clk);
            #2 start[inst] = 1'b1; base[inst] = 32'h5000;
            @(posedge clk); #2 start[inst] = 1'b0;
        end

        waited = 0;
        while (count_dn(inst, dn0) == 0 && waited < 20000) begin
            @(posedge clk);
            waited++;
        end
        check({tag, "_timeout"}, 32'(waited >= 20000), 0);
        repeat (4) @(posedge clk);
        #2;

        col_hs.delete();
        col_gr.delete();
        for (int k = hs0; k < hs_q.size(); k++) if (hs_q[k].inst == inst) col_hs.push_back(hs_q[k]);
        for (int k = gr0; k < gr_q.size(); k++) if (gr_q[k].inst == inst) col_gr.push_back(gr_q[k]);

        check({tag, "_pix_count"}, col_hs.size(), n_pix);
        for (int n = 0; n < n_pix && n < col_hs.size(); n++)
            check($sformatf("%s_px%0d", tag, n), {22'd0, col_hs[n].v},
                  {22'd0, (n == n_pix - 1), (n % w == 0), mem_byte(a0 + n)});
        check({tag, "_grant_count"}, col_gr.size(), n_words);
        for (int k = 0; k < n_words && k < col_gr.size(); k++)
            check($sformatf("%s_addr%0d", tag, k), col_gr[k].a, a0 + 32'(4 * k));
        check({tag, "_done_count"}, count_dn(inst, dn0), 1);
        if (count_dn(inst, dn0) > 0 && col_hs.size() > 0)
            for (int k = dn0; k < dn_q.size(); k++)
                if (dn_q[k].inst == inst)
                    check({tag, "_done_lat"}, dn_q[k].cyc - col_hs[col_hs.size() - 1].cyc, 1);
        if (!stall_mode[inst] && col_gr.size() > 0 && col_hs.size() > 0) begin
            check({tag, "_req_lat"}, col_gr[0].cyc - c0, 2);
            check({tag, "_pix_lat"}, col_hs[0].cyc - c0, 4);
        end
        check({tag, "_protocol"}, viol[inst] - v0, 0);
        check({tag, "_busy_end"}, {31'd0, busy[inst]}, 0);
    endtask

    initial begin
        int g0, h0, waited;
        checks = 0; errors = 0;
        ovr_en = 0; ovr_addr = '0; ovr_word = '0;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; start[i] = 1'b0; base[i] = '0;
            stall_mode[i] = 0; ready_mode[i] = 0; hold_rv[i] = 0; stray[i] = 0;
        end
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_ctl%0d", i),
                  {26'd0, busy[i], done[i], mem_req[i], valid[i], sol[i], eof[i]}, 0);
            check($sformatf("reset_addr%0d", i), addr[i], 0);
            check($sformatf("reset_pix%0d", i), {24'd0, pix[i]}, 0);
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // Full frame, zero-wait memory, consumer always ready.
        run_frame(0, $urandom & 32'hFFFF_FFFC, 28, 28, 0, "frame");

        // Known first word: lanes come out least significant byte first.
        ovr_en = 1; ovr_addr = 32'h2000; ovr_word = 32'h44332211;
        run_frame(0, 32'h2000, 28, 28, 0, "word");
        check("word_lane0", {24'd0, col_hs[0].v[7:0]}, 32'h11);
        check("word_lane1", {24'd0, col_hs[1].v[7:0]}, 32'h22);
        check("word_lane2", {24'd0, col_hs[2].v[7:0]}, 32'h33);
        check("word_lane3", {24'd0, col_hs[3].v[7:0]}, 32'h44);
        check("word_next_req", col_gr[1].cyc - col_hs[3].cyc, 1);
        ovr_en = 0;

        // Grant stalls and consumer back-pressure, unaligned random base.
        stall_mode[0] = 1; ready_mode[0] = 1;
        run_frame(0, $urandom, 28, 28, 0, "stall");
        stall_mode[0] = 0; ready_mode[0] = 0;

        // Second start while busy must be ignored; base is word-aligned.
        run_frame(0, 32'h1003, 28, 28, 1, "dblstart");

        // Small frame: last word only partly used; address wrap at the top.
        run_frame(1, 32'h0000_0040, 5, 3, 0, "small");
        stall_mode[1] = 1; ready_mode[1] = 1;
        run_frame(1, 32'hFFFF_FFF8, 5, 3, 0, "wrap");
        stall_mode[1] = 0; ready_mode[1] = 0;

        // Reset while waiting for read data, then a stray rvalid.
        hold_rv[1] = 1;
        g0 = gr_q.size();
        @(posedge clk); #2 base[1] = 32'h300; start[1] = 1'b1;
        @(posedge clk); #2 start[1] = 1'b0;
        waited = 0;
        while (count_gr(1, g0) == 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        check("rstwait_grant_timeout", 32'(waited >= 50), 0);
        repeat (2) @(posedge clk);
        #2 rst_n[1] = 1'b0;
        #1;
        check("rstwait_ctl", {26'd0, busy[1], done[1], mem_req[1], valid[1], sol[1], eof[1]}, 0);
        check("rstwait_addr", addr[1], 0);
        check("rstwait_pix", {24'd0, pix[1]}, 0);
        @(posedge clk); #2 rst_n[1] = 1'b1; hold_rv[1] = 0; stray[1] = 1;
        h0 = hs_q.size();
        @(posedge clk); #2 stray[1] = 0;
        repeat (3) @(posedge clk);
        #2;
        check("stray_busy", {31'd0, busy[1]}, 0);
        check("stray_no_pix", hs_q.size() - h0, 0);
        run_frame(1, 32'h300, 5, 3, 0, "restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
